// File: rtl/cpu_defines.sv
// Shared CPU pipeline definitions: enable/zero constants, EX->MEM payload layout
// and the pipeline stage buffer occupancy states.
package cpu_defines;

  localparam logic        ENABLE    = 1'b1;
  localparam logic        DISABLE   = 1'b0;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [4:0]  REG_ZERO  = 5'b00000;

  typedef struct packed {
    logic        wreg_write;
    logic [4:0]  wreg_addr;
    logic [31:0] wreg_data;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
  } ex_mem_payload_t;

  // What an empty EX->MEM stage must present: all writes disabled, zero address/data
  localparam ex_mem_payload_t EX_MEM_EMPTY = '{
    wreg_write: DISABLE,
    wreg_addr:  REG_ZERO,
    wreg_data:  ZERO_WORD,
    whilo:      DISABLE,
    hi:         ZERO_WORD,
    lo:         ZERO_WORD
  };

  // Encodings equal the number of held entries so occupancy is the state itself
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_t;

endpackage

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register: packs the EX results into ex_mem_payload_t and
// carries them through a pipe_stage_buf.
module ex_mem_stage
  import cpu_defines::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_wreg_write,
  input  logic [4:0]       in_wreg_addr,
  input  logic [31:0]      in_wreg_data,
  input  logic             in_whilo,
  input  logic [31:0]      in_hi,
  input  logic [31:0]      in_lo,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_wreg_write,
  output logic [4:0]       out_wreg_addr,
  output logic [31:0]      out_wreg_data,
  output logic             out_whilo,
  output logic [31:0]      out_hi,
  output logic [31:0]      out_lo,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  ex_mem_payload_t in_payload_s;
  ex_mem_payload_t buf_payload_s;
  ex_mem_payload_t out_payload_s;

  assign in_payload_s = '{
    wreg_write: in_wreg_write,
    wreg_addr:  in_wreg_addr,
    wreg_data:  in_wreg_data,
    whilo:      in_whilo,
    hi:         in_hi,
    lo:         in_lo
  };

  pipe_stage_buf #(
    .WIDTH($bits(ex_mem_payload_t)),
    .CNT_W(CNT_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (buf_payload_s),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  // The buffer already zeroes an empty stage; the empty encoding is pinned here too
  assign out_payload_s  = (out_valid == ENABLE) ? buf_payload_s : EX_MEM_EMPTY;
  assign out_wreg_write = out_payload_s.wreg_write;
  assign out_wreg_addr  = out_payload_s.wreg_addr;
  assign out_wreg_data  = out_payload_s.wreg_data;
  assign out_whilo      = out_payload_s.whilo;
  assign out_hi         = out_payload_s.hi;
  assign out_lo         = out_payload_s.lo;

endmodule

// File: rtl/pipe_stage_buf.sv
// Flow-controlled pipeline stage register with one skid entry, flush and a
// saturating stall-cycle counter. Payload reads as all-zero when the stage is empty.
module pipe_stage_buf
  import cpu_defines::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  stage_state_t     state_r, state_s;
  logic [WIDTH-1:0] main_r, main_s;
  logic [WIDTH-1:0] skid_r, skid_s;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic             in_fire_s, out_fire_s;

  // Next-state and next-payload selection for main and skid entries
  always_comb begin
    in_fire_s  = in_valid & in_ready_r;
    out_fire_s = out_valid_r & out_ready;
    state_s    = state_r;
    main_s     = main_r;
    skid_s     = skid_r;
    if (flush) begin
      state_s = ST_EMPTY;
      main_s  = {WIDTH{1'b0}};
      skid_s  = {WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_fire_s) begin
            state_s = ST_ONE;
            main_s  = in_data;
          end else begin
            state_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (out_fire_s && in_fire_s) begin
            main_s = in_data;
          end else if (out_fire_s) begin
            state_s = ST_EMPTY;
            main_s  = {WIDTH{1'b0}};
          end else if (in_fire_s) begin
            state_s = ST_FULL;
            skid_s  = in_data;
          end else begin
            state_s = ST_ONE;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the drain path can move
          if (out_fire_s) begin
            state_s = ST_ONE;
            main_s  = skid_r;
            skid_s  = {WIDTH{1'b0}};
          end else begin
            state_s = ST_FULL;
          end
        end
        default: begin
          state_s = ST_EMPTY;
          main_s  = {WIDTH{1'b0}};
          skid_s  = {WIDTH{1'b0}};
        end
      endcase
    end
  end

  // State, payload, handshake flags and stall counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_EMPTY;
      main_r      <= {WIDTH{1'b0}};
      skid_r      <= {WIDTH{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      stall_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_s;
      main_r      <= main_s;
      skid_r      <= skid_s;
      in_ready_r  <= (state_s != ST_FULL);
      out_valid_r <= (state_s != ST_EMPTY);
      if (out_valid_r && !out_ready && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = main_r;
  assign occupancy = state_r;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: queue scoreboard for the main instance,
// plus a CNT_W=4 instance for saturation and the ex_mem_stage wrapper.
module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;

  logic        s_flush, s_in_valid, s_out_ready;
  logic [31:0] s_in_data;
  logic        s_in_ready, s_out_valid;
  logic [31:0] s_out_data;
  logic [1:0]  s_occupancy;
  logic [3:0]  s_stall_cnt;

  logic        e_flush, e_in_valid, e_out_ready;
  logic        e_in_wreg_write, e_in_whilo;
  logic [4:0]  e_in_wreg_addr;
  logic [31:0] e_in_wreg_data, e_in_hi, e_in_lo;
  logic        e_in_ready, e_out_valid;
  logic        e_out_wreg_write, e_out_whilo;
  logic [4:0]  e_out_wreg_addr;
  logic [31:0] e_out_wreg_data, e_out_hi, e_out_lo;
  logic [1:0]  e_occupancy;
  logic [15:0] e_stall_cnt;

  int checks_total  = 0;
  int checks_passed = 0;

  logic [31:0] exp_q[$];
  logic [15:0] m_stall;
  logic        known = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_stage_buf #(.WIDTH(32), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .flush(s_flush), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_data(s_out_data), .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
  );

  ex_mem_stage #(.CNT_W(16)) dut_exm (
    .clk(clk), .rst(rst), .flush(e_flush), .in_valid(e_in_valid), .in_ready(e_in_ready),
    .in_wreg_write(e_in_wreg_write), .in_wreg_addr(e_in_wreg_addr),
    .in_wreg_data(e_in_wreg_data), .in_whilo(e_in_whilo), .in_hi(e_in_hi), .in_lo(e_in_lo),
    .out_valid(e_out_valid), .out_ready(e_out_ready),
    .out_wreg_write(e_out_wreg_write), .out_wreg_addr(e_out_wreg_addr),
    .out_wreg_data(e_out_wreg_data), .out_whilo(e_out_whilo), .out_hi(e_out_hi),
    .out_lo(e_out_lo), .occupancy(e_occupancy), .stall_cnt(e_stall_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_total++;
    if (obs === exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare main DUT against the queue model, advance the model with the current inputs, clock once
  task automatic step();
    logic ofire, ifire;
    if (known) begin
      check("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() != 0});
      check("in_ready", {63'd0, in_ready}, {63'd0, exp_q.size() < 2});
      check("occupancy", {62'd0, occupancy}, 64'(exp_q.size()));
      check("out_data", {32'd0, out_data}, (exp_q.size() != 0) ? {32'd0, exp_q[0]} : 64'd0);
      check("stall_cnt", {48'd0, stall_cnt}, {48'd0, m_stall});
    end
    if (rst) begin
      exp_q.delete();
      m_stall = 16'd0;
    end else if (known) begin
      ofire = (exp_q.size() != 0) && out_ready;
      ifire = in_valid && (exp_q.size() < 2);
      if ((exp_q.size() != 0) && !out_ready && (m_stall != 16'hFFFF)) m_stall = m_stall + 16'd1;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (ofire) void'(exp_q.pop_front());
        if (ifire) exp_q.push_back(in_data);
      end
    end
    if (rst) known = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b0;
    s_flush = 1'b0; s_in_valid = 1'b0; s_in_data = 32'h0; s_out_ready = 1'b0;
    e_flush = 1'b0; e_in_valid = 1'b0; e_out_ready = 1'b0;
    e_in_wreg_write = 1'b0; e_in_wreg_addr = 5'd0; e_in_wreg_data = 32'd0;
    e_in_whilo = 1'b0; e_in_hi = 32'd0; e_in_lo = 32'd0;
    m_stall = 16'd0;

    // Reset with an offered input that must be ignored
    step(); step();
    rst = 1'b0; in_valid = 1'b0;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", {32'd0, out_data}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_occupancy", {62'd0, occupancy}, 64'd0);
    check("rst_stall_cnt", {48'd0, stall_cnt}, 64'd0);

    // Streaming at full throughput
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data = 32'(i);
      step();
      check("stream_data", {32'd0, out_data}, 64'(i));
      check("stream_in_ready", {63'd0, in_ready}, 64'd1);
    end
    in_valid = 1'b0;
    step(); step();

    // Back-pressure fills the skid, 0xC waits upstream
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    step();
    in_data = 32'hB;
    step();
    check("bp_occupancy", {62'd0, occupancy}, 64'd2);
    check("bp_in_ready", {63'd0, in_ready}, 64'd0);
    in_data = 32'hC;
    step(); step(); step();
    check("bp_stall_cnt", {48'd0, stall_cnt}, 64'd4);
    check("bp_head", {32'd0, out_data}, 64'hA);
    out_ready = 1'b1;
    step();
    check("drain_b", {32'd0, out_data}, 64'hB);
    step();
    check("drain_c", {32'd0, out_data}, 64'hC);
    in_valid = 1'b0;
    step(); step();

    // Flush while full, with 0x55 offered in the same cycle
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11;
    step();
    in_data = 32'h22;
    step();
    in_data = 32'h55; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", {63'd0, out_valid}, 64'd0);
    check("flush_out_data", {32'd0, out_data}, 64'd0);
    check("flush_occupancy", {62'd0, occupancy}, 64'd0);
    check("flush_in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    step(); step();

    // Saturation on the 4-bit counter instance
    s_in_valid = 1'b1; s_in_data = 32'h7;
    step();
    s_in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("sat_partial", {60'd0, s_stall_cnt}, 64'd5);
    for (int i = 0; i < 15; i++) step();
    check("sat_stall_cnt", {60'd0, s_stall_cnt}, 64'd15);
    step(); step(); step();
    check("sat_hold", {60'd0, s_stall_cnt}, 64'd15);
    check("sat_data_stable", {32'd0, s_out_data}, 64'h7);
    check("sat_occupancy", {62'd0, s_occupancy}, 64'd1);

    // EX->MEM wrapper packs and unpacks every field
    e_in_valid = 1'b1; e_out_ready = 1'b1;
    e_in_wreg_write = 1'b1; e_in_wreg_addr = 5'h1F; e_in_wreg_data = 32'h12345678;
    e_in_whilo = 1'b1; e_in_hi = 32'hAAAA0000; e_in_lo = 32'h0000BBBB;
    step();
    e_in_valid = 1'b0;
    check("exm_valid", {63'd0, e_out_valid}, 64'd1);
    check("exm_wreg_write", {63'd0, e_out_wreg_write}, 64'd1);
    check("exm_wreg_addr", {59'd0, e_out_wreg_addr}, 64'h1F);
    check("exm_wreg_data", {32'd0, e_out_wreg_data}, 64'h12345678);
    check("exm_whilo", {63'd0, e_out_whilo}, 64'd1);
    check("exm_hi", {32'd0, e_out_hi}, 64'hAAAA0000);
    check("exm_lo", {32'd0, e_out_lo}, 64'h0000BBBB);
    step();
    check("exm_empty_write", {63'd0, e_out_wreg_write}, 64'd0);
    check("exm_empty_data", {32'd0, e_out_wreg_data}, 64'd0);
    check("exm_empty_hi", {32'd0, e_out_hi}, 64'd0);

    // Random valid/ready with ~5% flush against the scoreboard
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 60);
      flush     = ($urandom_range(0, 99) < 5);
      in_data   = $urandom;
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step(); step(); step();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
